// File: rtl/uart_write_if.sv
// uart_write_if: byte-write handshake and serial-side status of the UART transmitter.
// master = CPU-side writer, slave = the transmitter itself.
interface uart_write_if;
    logic       send_ce;
    logic [7:0] din;
    logic       full;
    logic       busy;
    logic       tfin;
    logic       txd;

    modport master (
        output send_ce,
        output din,
        input  full,
        input  busy,
        input  tfin,
        input  txd
    );

    modport slave (
        input  send_ce,
        input  din,
        output full,
        output busy,
        output tfin,
        output txd
    );
endinterface

// File: rtl/uart_write.sv
// uart_write: bit-rate-clocked UART transmitter with a small byte FIFO.
// Frames are 8N1 / 8N2 (STOP_BITS), LSB first, one clock per bit.
// Optional feature macro: UART_WRITE_PARITY_EN adds an even-parity bit after d7.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) on the line
// DATA   | data bit idx on the line
// PARITY | even-parity bit on the line (macro builds only)
// STOP   | stop bit(s) on the line; last one may chain into the next frame
module uart_write #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_write_if.slave   bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_WRITE_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [7:0]       sr;
    logic [2:0]       idx;
    logic             stop_cnt;
    logic             txd_q;
    logic             tfin_q;
    logic             full_q;
    logic             busy_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic             push;
    logic             pop;
    logic             stop_last;
    logic             frame_end;
    logic             goes_idle;

    // Pop only from a non-empty FIFO, either from IDLE or at the final stop edge
    // so consecutive frames chain without an idle bit.
    assign push      = bus.send_ce && !full_q;
    assign stop_last = (STOP_BITS == 1) || stop_cnt;
    assign frame_end = (state == STOP) && stop_last;
    assign pop       = (count != '0) && ((state == IDLE) || frame_end);
    assign goes_idle = ((state == IDLE) || frame_end) && !pop;

    // Occupancy after this edge; push and pop together cancel out.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.din;
    end

    // FIFO pointers, count and the registered full/busy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_next;
            full_q <= (count_next == CNT_W'(FIFO_DEPTH));
            busy_q <= (count_next != '0) || !goes_idle;
        end
    end

    // Frame sequencer: drives txd one bit per clock and pulses tfin at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            txd_q    <= 1'b1;
            tfin_q   <= 1'b0;
        end else begin
            tfin_q <= 1'b0;
            case (state)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        sr    <= mem[rd_ptr];
                        state <= START;
                        txd_q <= 1'b0;
                    end
                end
                START: begin
                    txd_q <= sr[0];
                    idx   <= 3'd0;
                    state <= DATA;
                end
                DATA: begin
                    if (idx == 3'd7) begin
`ifdef UART_WRITE_PARITY_EN
                        state <= PARITY;
                        txd_q <= ^sr;
`else
                        state    <= STOP;
                        txd_q    <= 1'b1;
                        stop_cnt <= 1'b0;
`endif
                    end else begin
                        idx   <= idx + 3'd1;
                        txd_q <= sr[idx + 3'd1];
                    end
                end
`ifdef UART_WRITE_PARITY_EN
                PARITY: begin
                    state    <= STOP;
                    txd_q    <= 1'b1;
                    stop_cnt <= 1'b0;
                end
`endif
                STOP: begin
                    txd_q <= 1'b1;
                    if (stop_last) begin
                        tfin_q <= 1'b1;
                        if (pop) begin
                            sr    <= mem[rd_ptr];
                            state <= START;
                            txd_q <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.txd  = txd_q;
    assign bus.tfin = tfin_q;
    assign bus.full = full_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_uart_write.sv
// tb_uart_write: directed tests for uart_write (default 1 stop bit, plus a 2-stop-bit instance).
module tb_uart_write;

`ifdef UART_WRITE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L1 = 9 + PAR + 1;
    localparam int L2 = 9 + PAR + 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_write_if bus1 ();
    uart_write_if bus2 ();

    uart_write #(.FIFO_DEPTH(4), .STOP_BITS(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    uart_write #(.FIFO_DEPTH(4), .STOP_BITS(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // Expected line sequence, bit k = level during k-th bit time of the frame;
    // bits past the data/parity portion are stop/idle ones.
    function automatic logic [12:0] frame_of(input logic [7:0] b);
        logic [12:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (PAR == 1)
            f[9] = ^b;
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus1.send_ce = 1'b0; bus1.din = 8'h00;
        bus2.send_ce = 1'b0; bus2.din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (bus1.txd !== 1'b1)  begin errors++; $display("FAIL reset_txd got %b exp 1", bus1.txd); end
        if (bus1.tfin !== 1'b0) begin errors++; $display("FAIL reset_tfin got %b exp 0", bus1.tfin); end
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus1.busy); end
        if (bus1.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus1.full); end
        if (bus2.txd !== 1'b1)  begin errors++; $display("FAIL reset_txd2 got %b exp 1", bus2.txd); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_byte;
        logic [12:0] e;
        e = frame_of(8'hA5);
        bus1.din = 8'hA5; bus1.send_ce = 1'b1;
        tick();
        bus1.send_ce = 1'b0;
        checks++;
        if (bus1.busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_push got %b exp 1", bus1.busy); end
        for (int k = 0; k < L1; k++) begin
            tick();
            checks += 2;
            if (bus1.txd !== e[k])  begin errors++; $display("FAIL single_txd bit %0d got %b exp %b", k, bus1.txd, e[k]); end
            if (bus1.tfin !== 1'b0) begin errors++; $display("FAIL single_tfin_early bit %0d got %b exp 0", k, bus1.tfin); end
        end
        tick();
        checks += 3;
        if (bus1.tfin !== 1'b1) begin errors++; $display("FAIL single_tfin got %b exp 1", bus1.tfin); end
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", bus1.busy); end
        if (bus1.txd !== 1'b1)  begin errors++; $display("FAIL single_idle_txd got %b exp 1", bus1.txd); end
        tick();
        checks++;
        if (bus1.tfin !== 1'b0) begin errors++; $display("FAIL single_tfin_width got %b exp 0", bus1.tfin); end
    endtask

    task automatic test_back_to_back;
        logic [12:0] e0, e1;
        logic        exp_txd, exp_tfin;
        e0 = frame_of(8'h00);
        e1 = frame_of(8'hFF);
        bus1.din = 8'h00; bus1.send_ce = 1'b1;
        tick();
        bus1.din = 8'hFF;
        tick();
        bus1.send_ce = 1'b0;
        for (int k = 0; k <= 2 * L1 + 1; k++) begin
            if (k > 0) tick();
            exp_txd  = (k < L1) ? e0[k] : (k < 2 * L1) ? e1[k - L1] : 1'b1;
            exp_tfin = (k == L1) || (k == 2 * L1);
            checks += 2;
            if (bus1.txd !== exp_txd)   begin errors++; $display("FAIL b2b_txd cycle %0d got %b exp %b", k, bus1.txd, exp_txd); end
            if (bus1.tfin !== exp_tfin) begin errors++; $display("FAIL b2b_tfin cycle %0d got %b exp %b", k, bus1.tfin, exp_tfin); end
        end
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", bus1.busy); end
    endtask

    task automatic test_fifo_full;
        logic [7:0]  bytes [5];
        logic [12:0] e;
        logic        exp_txd, exp_tfin;
        int          rel;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        for (int c = 1; c <= 2 + 5 * L1 + 5; c++) begin
            if (c <= 6) begin
                bus1.din = 8'h11 * c;
                bus1.send_ce = 1'b1;
            end else begin
                bus1.send_ce = 1'b0;
            end
            tick();
            rel = c - 2;
            if (rel >= 0 && rel < 5 * L1) begin
                e = frame_of(bytes[rel / L1]);
                exp_txd = e[rel % L1];
            end else begin
                exp_txd = 1'b1;
            end
            exp_tfin = (rel > 0) && (rel % L1 == 0) && (rel <= 5 * L1);
            checks += 2;
            if (bus1.txd !== exp_txd)   begin errors++; $display("FAIL full_txd cycle %0d got %b exp %b", c, bus1.txd, exp_txd); end
            if (bus1.tfin !== exp_tfin) begin errors++; $display("FAIL full_tfin cycle %0d got %b exp %b", c, bus1.tfin, exp_tfin); end
            if (c == 4) begin
                checks++;
                if (bus1.full !== 1'b0) begin errors++; $display("FAIL full_after_w4 got %b exp 0", bus1.full); end
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (bus1.full !== 1'b1) begin errors++; $display("FAIL full_after_w%0d got %b exp 1", c, bus1.full); end
            end
            if (c == 2 + L1) begin
                checks++;
                if (bus1.full !== 1'b0) begin errors++; $display("FAIL full_after_pop got %b exp 0", bus1.full); end
            end
        end
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b exp 0", bus1.busy); end
    endtask

    task automatic test_reset_mid;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1)      begin bus1.din = 8'h3C; bus1.send_ce = 1'b1; end
            else if (c == 2) begin bus1.din = 8'hA1; bus1.send_ce = 1'b1; end
            else if (c == 3) begin bus1.din = 8'hB2; bus1.send_ce = 1'b1; end
            else             bus1.send_ce = 1'b0;
            tick();
        end
        checks += 2;
        if (bus1.txd !== 1'b1)  begin errors++; $display("FAIL rstmid_d3 got %b exp 1", bus1.txd); end
        if (bus1.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", bus1.busy); end
        #2;
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus1.txd !== 1'b1)  begin errors++; $display("FAIL rstmid_txd_async got %b exp 1", bus1.txd); end
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async got %b exp 0", bus1.busy); end
        if (bus1.tfin !== 1'b0) begin errors++; $display("FAIL rstmid_tfin_async got %b exp 0", bus1.tfin); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3 * L1; k++) begin
            tick();
            checks += 4;
            if (bus1.txd !== 1'b1)  begin errors++; $display("FAIL rstmid_txd cycle %0d got %b exp 1", k, bus1.txd); end
            if (bus1.tfin !== 1'b0) begin errors++; $display("FAIL rstmid_tfin cycle %0d got %b exp 0", k, bus1.tfin); end
            if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy cycle %0d got %b exp 0", k, bus1.busy); end
            if (bus1.full !== 1'b0) begin errors++; $display("FAIL rstmid_full cycle %0d got %b exp 0", k, bus1.full); end
        end
    endtask

    task automatic test_two_stop;
        logic [12:0] e;
        e = frame_of(8'h81);
        bus2.din = 8'h81; bus2.send_ce = 1'b1;
        tick();
        bus2.send_ce = 1'b0;
        for (int k = 0; k < L2; k++) begin
            tick();
            checks += 2;
            if (bus2.txd !== e[k])  begin errors++; $display("FAIL stop2_txd bit %0d got %b exp %b", k, bus2.txd, e[k]); end
            if (bus2.tfin !== 1'b0) begin errors++; $display("FAIL stop2_tfin_early bit %0d got %b exp 0", k, bus2.tfin); end
        end
        tick();
        checks += 2;
        if (bus2.tfin !== 1'b1) begin errors++; $display("FAIL stop2_tfin got %b exp 1", bus2.tfin); end
        if (bus2.busy !== 1'b0) begin errors++; $display("FAIL stop2_busy_end got %b exp 0", bus2.busy); end
    endtask

`ifdef UART_WRITE_PARITY_EN
    task automatic test_parity;
        logic [7:0] b;
        logic       pexp;
        for (int t = 0; t < 2; t++) begin
            b    = (t == 0) ? 8'h07 : 8'h03;
            pexp = (t == 0) ? 1'b1 : 1'b0;
            bus1.din = b; bus1.send_ce = 1'b1;
            tick();
            bus1.send_ce = 1'b0;
            for (int k = 0; k < 11; k++) begin
                tick();
                if (k == 9) begin
                    checks++;
                    if (bus1.txd !== pexp) begin errors++; $display("FAIL parity_bit byte %h got %b exp %b", b, bus1.txd, pexp); end
                end
            end
            tick();
            checks++;
            if (bus1.tfin !== 1'b1) begin errors++; $display("FAIL parity_len byte %h tfin got %b exp 1", b, bus1.tfin); end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid();
        test_two_stop();
`ifdef UART_WRITE_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_write.md
# uart_write

Byte-serial UART transmitter, the transmit-side counterpart of the team's bit-rate-clocked UART receiver. It accepts bytes from the CPU-side UART controller into a small FIFO and shifts each one out on the serial line as an 8N1 frame: start bit, 8 data bits LSB first, stop bit(s). The clock runs at the baud rate (9600 bps), so one clock cycle equals one bit time. The block sits between the memory-mapped UART data register and the board's TXD pin.

## Interface
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥2.
- STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

- clk  input  1  bit-rate clock (9600 bps); one cycle = one bit time.
- rst  input  1  reset; asynchronous, active-high.
- send_ce  input  1  write strobe; pushes `din` into the FIFO when `full`=0.
- din  input  8  byte to transmit.
- full  output  1  FIFO holds FIFO_DEPTH entries; writes are ignored.
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
- tfin  output  1  one-cycle pulse after each frame's last stop bit.
- txd  output  1  serial line; idles high.

## Operation
- Reset values: txd=1, tfin=0, busy=0, full=0, FIFO empty (pointers and count = 0), FSM in IDLE, bit index = 0.
- FIFO:
  - Registered count, width clog2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
  - A push occurs at an edge where send_ce=1 and full=0. Writes while full are dropped silently, even if a pop happens at the same edge.
  - A pop occurs only when count>0 before the edge.
  - A simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, go to START, drive txd<=0.
  - START → DATA: txd<=sr[0], index=0.
  - DATA: each edge drives the next bit, LSB first. After sr[7] has been driven for one cycle, go to STOP (or PARITY) with txd<=1.
  - STOP: hold txd=1 for STOP_BITS cycles. At the final edge, assert tfin for one cycle. Then:
    - if the FIFO is non-empty, pop and go directly to START (txd<=0), giving back-to-back frames with no idle gap;
    - otherwise go to IDLE.
- send_ce and din are ignored except at push edges; the frame being transmitted is never affected by new writes.
- Reset mid-frame: txd returns to 1 immediately (asynchronously), the frame is truncated, and FIFO contents are discarded. No tfin is generated.

## Timing
- Frame length = 1 + 8 + STOP_BITS cycles, plus 1 with parity. Default: 10 cycles.
- Push accepted at edge W → start bit begins at edge W+1 when the FSM is IDLE. Latency is 1 cycle.
- Frame whose start bit begins at edge E0:
  - d0..d7 during E1..E8;
  - stop bit during E9 (plus E10 if STOP_BITS=2);
  - tfin high for the cycle beginning at E10 (default), concurrent with the next frame's start bit or with idle.
- full and busy are registered outputs and update on the edge of the push or pop that changes them.

## Configuration
- UART_WRITE_PARITY_EN:
  - Defined: an even-parity bit (XOR of the 8 data bits) is transmitted in a PARITY state between d7 and the stop bits. Frame length grows by 1; tfin shifts 1 cycle later.
  - Undefined: the PARITY state and its logic are absent; frames are 8N1/8N2.

## Test plan
- Single byte: write 0xA5 at edge W in idle → txd from W+1 = 0,1,0,1,0,0,1,0,1,1. tfin pulses at W+11. busy falls at W+11.
- Back-to-back: write 0x00 then 0xFF on consecutive edges → txd = 0, eight 0s, 1, 0, eight 1s, 1 with no idle gap. tfin fires twice, exactly 10 cycles apart.
- FIFO full (FIFO_DEPTH=4): write 0x11..0x66 on 6 consecutive edges → full rises after the 5th write, the 6th (0x66) is dropped, and 0x11..0x55 are transmitted in order.
- Reset mid-frame: assert rst during d3 of 0x3C with 2 bytes queued → txd=1 at once. After release, full=0, busy=0, no further frames, no tfin.
- STOP_BITS=2: single 0x81 → txd = 0,1,0,0,0,0,0,0,1,1,1. tfin one cycle after the second stop bit.
- With UART_WRITE_PARITY_EN: 0x07 → parity bit 1 after d7. 0x03 → parity bit 0. Frame length 11 cycles in both cases.
